fpga_regpipe: RTL and testbench
===============================

FPGA_REGPIPE -- requirements
Module: fpga_regpipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 SHALL have parameter RESET_VAL, default '0, WIDTH-bit value loaded into every data stage on reset.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port E_i, input, 1, clock enable / pipeline advance.
REQ-007 SHALL have port flush_i, input, 1, synchronous clear of all valid flags.
REQ-008 SHALL have port valid_i, input, 1, marks D_i as carrying data.
REQ-009 SHALL have port D_i, input, WIDTH, data in.
REQ-010 SHALL have port Q_o, output, WIDTH, data out of the last stage (registered).
REQ-011 SHALL have port valid_o, output, 1, valid flag of the last stage (registered).
REQ-012 SHALL have port count_o, output, CW = ceil(log2(DEPTH+1)), number of stages holding valid data.

Function
REQ-013 SHALL hold per stage k (0..DEPTH-1) a WIDTH-bit data register d[k] and a valid bit v[k]; Q_o=d[DEPTH-1], valid_o=v[DEPTH-1].
REQ-014 SHALL, on an edge with E_i=1 and flush_i=0, shift: d[0]<=D_i, v[0]<=valid_i, d[k]<=d[k-1], v[k]<=v[k-1].
REQ-015 SHALL, on an edge with E_i=0 and flush_i=0, hold all d[k] and v[k] unchanged.
REQ-016 SHALL have a latency of exactly DEPTH enabled edges from D_i/valid_i sampling to Q_o/valid_o; disabled edges do not count.
REQ-017 SHALL, on an edge with flush_i=1, clear all v[k] to 0 regardless of E_i; the word presented on D_i/valid_i that edge is discarded; d[k] follow REQ-014/015 per E_i.
REQ-018 SHALL drive count_o as the population count of v[0..DEPTH-1], updated the same edge as the valid bits; max value DEPTH, never wraps.
REQ-019 SHALL preserve bubbles: valid_i=0 words propagate as v=0 stages in order, never collapsed.
REQ-020 SHALL support DEPTH=1 (single register with enable, valid and flush), count_o 1 bit.

Reset
REQ-021 SHALL, while reset_i=1, force all d[k] to RESET_VAL, all v[k] to 0, count_o to 0, immediately without a clock edge.
REQ-022 SHALL take reset priority over flush_i and E_i; an assertion mid-stream discards all in-flight data.
REQ-023 SHALL resume normal operation at the first rising edge of clk_i after reset_i deasserts, with first output valid DEPTH enabled edges later.

Configuration
REQ-024 SHALL recognise macro FPGA_REGPIPE_GATE_EN.
REQ-025 SHALL, with FPGA_REGPIPE_GATE_EN defined, load d[k] on an enabled edge only when its incoming valid (valid_i for k=0, v[k-1] otherwise) is 1, otherwise holding d[k]; valid bits still shift per REQ-014.
REQ-026 SHALL, with FPGA_REGPIPE_GATE_EN undefined, load d[k] on every enabled edge regardless of valid; valid_o/count_o behaviour identical in both builds.

Verification (WIDTH=8, DEPTH=4, RESET_VAL=0x00)
REQ-027 SHALL cover reset: after streaming, assert reset_i between edges -> Q_o=0x00, valid_o=0, count_o=0 before next edge; deassert -> outputs hold until new data traverses 4 enabled edges.
REQ-028 SHALL cover streaming: E_i=1, valid_i=1, D_i=0x11,0x22,0x33,0x44,0x55 on consecutive edges -> Q_o=0x11 valid_o=1 after edge 4, 0x22 after edge 5; count_o=1,2,3,4,4.
REQ-029 SHALL cover stall: load 0x11,0x22, then E_i=0 for 3 edges -> all outputs held, count_o=2; E_i=1 with valid_i=0 -> Q_o=0x11 valid_o=1 after 2 further enabled edges.
REQ-030 SHALL cover flush: count_o=3, flush_i=1 and E_i=1 with valid_i=1 D_i=0x99 -> next edge valid_o=0, count_o=0; 0x99 never appears with valid_o=1.
REQ-031 SHALL cover bubbles: valid_i=1,0,1 with D_i=0x11,0xEE,0x33 -> valid_o=1,0,1 at edges 4,5,6; at edge 5 Q_o=0x11 with FPGA_REGPIPE_GATE_EN, Q_o=0xEE without.
REQ-032 SHALL cover DEPTH=1 build: D_i=0xA5 valid_i=1 E_i=1 -> Q_o=0xA5 valid_o=1 count_o=1 after one edge; flush_i=1 -> valid_o=0 next edge.

Source files
------------

// File: rtl/fpga_regpipe.sv
// Enable/flush register pipeline with per-stage valid bits and a live valid-stage count.
// Optional build macro FPGA_REGPIPE_GATE_EN: data registers only load when their incoming word is valid.
module fpga_regpipe_stage #(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    input  logic             vin,
    output logic [WIDTH-1:0] dout,
    output logic             vout
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (en) begin
`ifdef FPGA_REGPIPE_GATE_EN
            // Bubbles leave the data register untouched to save toggling.
            if (vin) dout <= din;
`else
            dout <= din;
`endif
        end
    end

    // Flush kills the valid flag even on a stalled edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        vout <= 1'b0;
        else if (flush) vout <= 1'b0;
        else if (en)    vout <= vin;
    end

endmodule

module fpga_regpipe #(
    parameter int                WIDTH     = 8,
    parameter int                DEPTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    localparam int               CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             E_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] D_i,
    output logic [WIDTH-1:0] Q_o,
    output logic             valid_o,
    output logic [CW-1:0]    count_o
);

    // Index 0 is the pipeline input; index k+1 is the output of stage k.
    logic [DEPTH:0][WIDTH-1:0] dat_pipe;
    logic [DEPTH:0]            vld_pipe;

    assign dat_pipe[0] = D_i;
    assign vld_pipe[0] = valid_i;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        fpga_regpipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk   (clk_i),
            .rst   (reset_i),
            .en    (E_i),
            .flush (flush_i),
            .din   (dat_pipe[k]),
            .vin   (vld_pipe[k]),
            .dout  (dat_pipe[k+1]),
            .vout  (vld_pipe[k+1])
        );
    end

    assign Q_o     = dat_pipe[DEPTH];
    assign valid_o = vld_pipe[DEPTH];

    // Popcount of registered valid bits; tracks them on the same edge and under reset.
    always_comb begin
        count_o = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            count_o = count_o + CW'(vld_pipe[k]);
        end
    end

endmodule

// File: tb/tb_fpga_regpipe.sv
// Directed bench for fpga_regpipe: DEPTH=4 main instance plus a DEPTH=1 instance.
module tb_fpga_regpipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, flush = 1'b0, vin = 1'b0;
    logic [7:0] d = 8'h00;
    logic [7:0] q;
    logic       vo;
    logic [2:0] cnt;

    logic       en1 = 1'b0, flush1 = 1'b0, vin1 = 1'b0;
    logic [7:0] d1 = 8'h00;
    logic [7:0] q1;
    logic       vo1;
    logic [0:0] cnt1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpga_regpipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
        .clk_i(clk), .reset_i(rst), .E_i(en), .flush_i(flush), .valid_i(vin),
        .D_i(d), .Q_o(q), .valid_o(vo), .count_o(cnt)
    );

    fpga_regpipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut1 (
        .clk_i(clk), .reset_i(rst), .E_i(en1), .flush_i(flush1), .valid_i(vin1),
        .D_i(d1), .Q_o(q1), .valid_o(vo1), .count_o(cnt1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge; pulses reset well before the next edge.
    task automatic apply_reset();
        rst = 1'b1; en = 1'b0; flush = 1'b0; vin = 1'b0; d = 8'h00;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (q !== 8'h00 || vo !== 1'b0 || cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_init: q=%h vo=%b cnt=%0d want q=00 vo=0 cnt=0", q, vo, cnt);
        end
        checks++;
        if (q1 !== 8'h00 || vo1 !== 1'b0 || cnt1 !== 1'd0) begin
            errors++;
            $display("FAIL reset_init_d1: q=%h vo=%b cnt=%0d want q=00 vo=0 cnt=0", q1, vo1, cnt1);
        end
        #10;
        rst = 1'b0;
        step();
    endtask

    task automatic test_stream();
        logic [7:0] data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [2:0] ecnt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        apply_reset();
        en = 1'b1; vin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = data[i];
            step();
            checks++;
            if (cnt !== ecnt[i]) begin
                errors++;
                $display("FAIL stream_cnt[%0d]: got %0d want %0d", i, cnt, ecnt[i]);
            end
            checks++;
            if (i >= 3) begin
                if (vo !== 1'b1 || q !== data[i-3]) begin
                    errors++;
                    $display("FAIL stream_out[%0d]: q=%h vo=%b want q=%h vo=1", i, q, vo, data[i-3]);
                end
            end else if (vo !== 1'b0) begin
                errors++;
                $display("FAIL stream_out[%0d]: vo=%b want 0", i, vo);
            end
        end
    endtask

    // Pipeline is full from test_stream when this starts.
    task automatic test_reset_midstream();
        rst = 1'b1;
        #1;
        checks++;
        if (q !== 8'h00 || vo !== 1'b0 || cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_async: q=%h vo=%b cnt=%0d want q=00 vo=0 cnt=0", q, vo, cnt);
        end
        #1;
        rst = 1'b0;
        en = 1'b1; vin = 1'b1; d = 8'h5A;
        step();
        vin = 1'b0; d = 8'h00;
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (vo !== 1'b0 || q !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold[%0d]: q=%h vo=%b want q=00 vo=0", i, q, vo);
            end
            step();
        end
        checks++;
        if (vo !== 1'b1 || q !== 8'h5A) begin
            errors++;
            $display("FAIL reset_resume: q=%h vo=%b want q=5a vo=1", q, vo);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        en = 1'b1; vin = 1'b1;
        d = 8'h11; step();
        d = 8'h22; step();
        en = 1'b0; d = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (cnt !== 3'd2 || vo !== 1'b0 || q !== 8'h00) begin
                errors++;
                $display("FAIL stall_hold[%0d]: q=%h vo=%b cnt=%0d want q=00 vo=0 cnt=2", i, q, vo, cnt);
            end
        end
        en = 1'b1; vin = 1'b0; d = 8'h00;
        step();
        checks++;
        if (vo !== 1'b0) begin
            errors++;
            $display("FAIL stall_resume1: vo=%b want 0", vo);
        end
        step();
        checks++;
        if (vo !== 1'b1 || q !== 8'h11 || cnt !== 3'd2) begin
            errors++;
            $display("FAIL stall_resume2: q=%h vo=%b cnt=%0d want q=11 vo=1 cnt=2", q, vo, cnt);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        en = 1'b1; vin = 1'b1;
        d = 8'h01; step();
        d = 8'h02; step();
        d = 8'h03; step();
        checks++;
        if (cnt !== 3'd3) begin
            errors++;
            $display("FAIL flush_pre_cnt: got %0d want 3", cnt);
        end
        flush = 1'b1; d = 8'h99;
        step();
        checks++;
        if (vo !== 1'b0 || cnt !== 3'd0) begin
            errors++;
            $display("FAIL flush_clear: vo=%b cnt=%0d want vo=0 cnt=0", vo, cnt);
        end
        flush = 1'b0; vin = 1'b0; d = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (vo !== 1'b0 || cnt !== 3'd0) begin
                errors++;
                $display("FAIL flush_drain[%0d]: q=%h vo=%b cnt=%0d want vo=0 cnt=0", i, q, vo, cnt);
            end
        end
    endtask

    task automatic test_bubbles();
        logic       vins [3] = '{1'b1, 1'b0, 1'b1};
        logic [7:0] data [3] = '{8'h11, 8'hEE, 8'h33};
        logic       evo  [3] = '{1'b1, 1'b0, 1'b1};
`ifdef FPGA_REGPIPE_GATE_EN
        logic [7:0] eq   [3] = '{8'h11, 8'h11, 8'h33};
`else
        logic [7:0] eq   [3] = '{8'h11, 8'hEE, 8'h33};
`endif
        apply_reset();
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                vin = vins[i]; d = data[i];
            end else begin
                vin = 1'b0; d = 8'h00;
            end
            step();
            if (i >= 3) begin
                checks++;
                if (vo !== evo[i-3] || q !== eq[i-3]) begin
                    errors++;
                    $display("FAIL bubble_edge%0d: q=%h vo=%b want q=%h vo=%b", i+1, q, vo, eq[i-3], evo[i-3]);
                end
            end
        end
    endtask

    task automatic test_depth1();
        en1 = 1'b1; vin1 = 1'b1; d1 = 8'hA5;
        step();
        checks++;
        if (q1 !== 8'hA5 || vo1 !== 1'b1 || cnt1 !== 1'd1) begin
            errors++;
            $display("FAIL d1_load: q=%h vo=%b cnt=%0d want q=a5 vo=1 cnt=1", q1, vo1, cnt1);
        end
        flush1 = 1'b1;
        step();
        checks++;
        if (vo1 !== 1'b0 || cnt1 !== 1'd0) begin
            errors++;
            $display("FAIL d1_flush: vo=%b cnt=%0d want vo=0 cnt=0", vo1, cnt1);
        end
        flush1 = 1'b0; en1 = 1'b0; d1 = 8'h3C;
        step();
        checks++;
        if (vo1 !== 1'b0 || q1 !== 8'hA5) begin
            errors++;
            $display("FAIL d1_hold: q=%h vo=%b want q=a5 vo=0", q1, vo1);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_reset_midstream();
        test_stall();
        test_flush();
        test_bubbles();
        test_depth1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
